// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, FSM state encoding and one-hot helper for the 16-source round-robin arbiter
//   N_SRC    number of requesters sharing the mux
//   SEL_W    width of the mux select / source index
//   state_t  arbiter state, IDLE (no owner) or BUSY (one owner)
//   onehot16 index -> [0:15] one-hot vector, bit idx set
package mux_arb_pkg;
    localparam int N_SRC = 16;
    localparam int SEL_W = 4;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    function automatic logic [0:15] onehot16(input logic [0:3] idx);
        onehot16 = '0;
        onehot16[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational rotating-priority picker, first set request scanning from ptr upward with wrap
//   req_i [0:15] candidate requests
//   ptr_i [0:3]  highest-priority index
//   any_o        at least one candidate set
//   idx_o [0:3]  winning index (0 when any_o=0)
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [0:15] req_i,
    input  logic [0:3]  ptr_i,
    output logic        any_o,
    output logic [0:3]  idx_o
);
    logic [3:0] j;
    assign any_o = |req_i;
    // Scan from the lowest priority back to ptr so the last hit is the winner.
    always_comb begin
        idx_o = '0;
        j = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = ptr_i + 4'(k);
            if (req_i[j]) idx_o = j;
        end
    end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter driving the select of a shared 16:1 mux; optional hold timeout via ARB_TIMEOUT_EN
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_i      [0:15] per-source requests, req_i[i] maps to mux input i
//   gnt_o      [0:15] registered one-hot grant, zero when idle
//   sel_o      [0:3]  registered mux select (sel_o[0] is MSB), holds last winner while idle
//   valid_o    grant active
//   expired_o  one-cycle pulse when a grant is revoked by the hold timeout (tied 0 without ARB_TIMEOUT_EN)
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int RESET_PTR = 0,
    parameter int MAX_HOLD  = 8,
    parameter int HOLD_W    = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [0:15] req_i,
    output logic [0:15] gnt_o,
    output logic [0:3]  sel_o,
    output logic        valid_o,
    output logic        expired_o
);
    if (MAX_HOLD < 1 || (1 << HOLD_W) < MAX_HOLD) begin : g_bad_cfg
        $error("mux16_rr_arbiter: MAX_HOLD must be >=1 and fit in HOLD_W bits");
    end
    state_t      state_q;
    logic [0:15] gnt_q;
    logic [0:3]  sel_q;
    logic [0:3]  ptr_q;
    logic [0:15] cand;
    logic        any;
    logic [0:3]  win;
    logic        keep;
    logic        tmo;
    // The owner is never a candidate: on release its request is already low,
    // and on timeout it must yield to someone else.
    assign cand = (state_q == BUSY) ? req_i & ~onehot16(sel_q) : req_i;
    rr_pick16 u_pick (
        .req_i (cand),
        .ptr_i (ptr_q),
        .any_o (any),
        .idx_o (win)
    );
    assign keep = (state_q == BUSY) && req_i[sel_q] && !tmo;
`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q;
    logic              expired_q;
    assign tmo = (state_q == BUSY) && req_i[sel_q] && any && hold_q == HOLD_W'(MAX_HOLD - 1);
    // Saturating at MAX_HOLD-1 lets a lone owner keep the grant yet yield
    // on the first edge another source shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= tmo;
            hold_q    <= keep ? ((hold_q == HOLD_W'(MAX_HOLD - 1)) ? hold_q : hold_q + 1'b1) : '0;
        end
    end
    assign expired_o = expired_q;
`else
    assign tmo       = 1'b0;
    assign expired_o = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= 4'(RESET_PTR);
        end else if (!keep) begin
            if (any) begin
                state_q <= BUSY;
                gnt_q   <= onehot16(win);
                sel_q   <= win;
                ptr_q   <= win + 4'd1;
            end else begin
                state_q <= IDLE;
                gnt_q   <= '0;
            end
        end
    end
    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = (state_q == BUSY);
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and randomized checks of mux16_rr_arbiter against a behavioural owner/pointer model
module tb_mux16_rr_arbiter;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [0:15] req;
    logic [0:15] gnt;
    logic [0:3]  sel;
    logic        valid;
    logic        expired;
    int vectors = 0;
    int miscompares = 0;
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;
    bit m_exp;

    mux16_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .valid_o   (valid),
        .expired_o (expired)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [0:15] r, input int p);
        for (int k = 0; k < 16; k++)
            if (r[(p + k) % 16]) return (p + k) % 16;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_step(input logic [0:15] r);
        logic [0:15] others;
        bit kept;
        bit to;
        int w;
        others = r;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        kept = (m_owner >= 0) && r[m_owner];
        to = TMO && kept && (m_hold == MAX_HOLD - 1) && (others != 0);
        m_exp = to;
        if (kept && !to) begin
            m_hold = (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
        end else begin
            w = pick(others, m_ptr);
            m_hold = 0;
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_ptr   = (w + 1) % 16;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [0:15] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("gnt", gnt, eg);
        check("sel", {12'd0, sel}, 16'(m_sel));
        check("valid", {15'd0, valid}, {15'd0, m_owner >= 0});
        check("expired", {15'd0, expired}, {15'd0, m_exp});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(req);
        #1;
        compare_all();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("async_gnt", gnt, 16'h0000);
        check("async_valid", {15'd0, valid}, 16'h0000);
        model_reset();
        compare_all();
        #2 rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [0:15] r;
        rst = 1'b1;
        req = 16'hFFFF;
        model_reset();
        #12;
        check("rst_gnt", gnt, 16'h0000);
        check("rst_sel", {12'd0, sel}, 16'h0000);
        check("rst_valid", {15'd0, valid}, 16'h0000);
        @(negedge clk) rst = 1'b0;
        tick();
        check("first_gnt", gnt, 16'h8000);
        check("first_sel", {12'd0, sel}, 16'h0000);
        for (int k = 1; k <= 16; k++) begin
            req = 16'hFFFF;
            req[sel] = 1'b0;
            tick();
            check("rot_sel", {12'd0, sel}, 16'(k % 16));
        end
        req = '0;
        tick();
        req = '0;
        req[4] = 1'b1;
        tick();
        req = '0;
        req[3] = 1'b1;
        req[9] = 1'b1;
        tick();
        check("sparse_sel9", {12'd0, sel}, 16'd9);
        req[9] = 1'b0;
        tick();
        check("sparse_sel3", {12'd0, sel}, 16'd3);
        check("sparse_valid", {15'd0, valid}, 16'd1);
        req = '0;
        tick();
        req[12] = 1'b1;
        tick();
        check("idle_gnt12a", gnt, 16'h0008);
        tick();
        check("idle_gnt12b", gnt, 16'h0008);
        req = '0;
        tick();
        check("idle_valid", {15'd0, valid}, 16'd0);
        check("idle_sel", {12'd0, sel}, 16'd12);
        req[2] = 1'b1;
        req[7] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt[2]) n++;
            else break;
        end
        if (TMO) begin
            check("tmo_cycles", 16'(n), 16'd8);
            check("tmo_expired", {15'd0, expired}, 16'd1);
            check("tmo_sel", {12'd0, sel}, 16'd7);
        end else begin
            check("notmo_cycles", 16'(n), 16'd20);
            check("notmo_expired", {15'd0, expired}, 16'd0);
        end
        req = '0;
        tick();
        req[5] = 1'b1;
        tick();
        mid_reset();
        tick();
        check("post_rst_sel", {12'd0, sel}, 16'd5);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: r = 16'($urandom);
                1: r = 16'($urandom & $urandom & $urandom);
                2: r = '0;
                default: r = 16'(1 << $urandom_range(0, 15));
            endcase
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            req = r;
            tick();
            if ($urandom_range(0, 199) == 0) mid_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
